// File: rtl/display_scheduler.sv
// Display frame sequencer and value arbiter for the shared 8-digit LED display.
// Requesters capture values, win the display by priority and hold it for HOLD_FRAMES frames.
module display_scheduler #(
  parameter int N_REQ       = 3,
  parameter int HOLD_FRAMES = 16,
  parameter int SRC_W       = 2
) (
  input  logic                 clk_out,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  val,
  output logic [N_REQ-1:0]     ack,
  input  logic [31:0]          idle_val,
  output logic [31:0]          disp_val,
  output logic [SRC_W-1:0]     disp_src,
  output logic                 cclr_neg,
  output logic                 blank,
  output logic [2:0]           digit_idx,
  output logic                 frame_done
);

  typedef enum logic [3:0] {
    ST_CLR   = 4'd0,
    ST_ARM   = 4'd1,
    ST_SCAN0 = 4'd2,
    ST_SCAN1 = 4'd3,
    ST_SCAN2 = 4'd4,
    ST_SCAN3 = 4'd5,
    ST_SCAN4 = 4'd6,
    ST_SCAN5 = 4'd7,
    ST_SCAN6 = 4'd8,
    ST_SCAN7 = 4'd9
  } frame_state_t;

  localparam logic [SRC_W-1:0] IDLE_SRC  = SRC_W'(N_REQ);
  localparam logic [7:0]       HOLD_INIT = 8'(HOLD_FRAMES);

  frame_state_t state_q, state_d;
  logic         cclr_neg_q, blank_q, frame_done_q;
  logic [2:0]   digit_idx_q;
  logic         cclr_neg_d, blank_d, frame_done_d;
  logic [2:0]   digit_idx_d;

  logic [31:0]      slot_q [N_REQ];
  logic [31:0]      slot_d [N_REQ];
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] ack_q;
  logic [31:0]      disp_val_q, disp_val_d;
  logic [SRC_W-1:0] disp_src_q, disp_src_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;

  logic             owner_s, expired_s, found_s, grant_s;
  logic [7:0]       hold_m1_s;
  logic [SRC_W-1:0] j_s;
  logic [N_REQ-1:0] grant_mask_s;

  // Lowest-index set bit of the pending vector; MSB of the result is the "found" flag.
  function automatic logic [SRC_W:0] first_pending(input logic [N_REQ-1:0] p);
    logic             found;
    logic [SRC_W-1:0] idx;
    found = 1'b0;
    idx   = {SRC_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      found = found | p[i];
      idx   = p[i] ? SRC_W'(i) : idx;
    end
    return {found, idx};
  endfunction

  // Frame sequence: CLR, ARM, then the eight scan slots.
  always_comb begin
    state_d = ST_CLR;
    case (state_q)
      ST_CLR:   state_d = ST_ARM;
      ST_ARM:   state_d = ST_SCAN0;
      ST_SCAN0: state_d = ST_SCAN1;
      ST_SCAN1: state_d = ST_SCAN2;
      ST_SCAN2: state_d = ST_SCAN3;
      ST_SCAN3: state_d = ST_SCAN4;
      ST_SCAN4: state_d = ST_SCAN5;
      ST_SCAN5: state_d = ST_SCAN6;
      ST_SCAN6: state_d = ST_SCAN7;
      ST_SCAN7: state_d = ST_CLR;
      default:  state_d = ST_CLR;
    endcase
  end

  // Output decode of the upcoming state so the display strobes come straight from flops.
  always_comb begin
    cclr_neg_d   = 1'b1;
    blank_d      = 1'b0;
    digit_idx_d  = 3'd0;
    frame_done_d = 1'b0;
    case (state_d)
      ST_CLR: begin
        cclr_neg_d = 1'b0;
        blank_d    = 1'b1;
      end
      ST_ARM:   blank_d = 1'b1;
      ST_SCAN0: digit_idx_d = 3'd0;
      ST_SCAN1: digit_idx_d = 3'd1;
      ST_SCAN2: digit_idx_d = 3'd2;
      ST_SCAN3: digit_idx_d = 3'd3;
      ST_SCAN4: digit_idx_d = 3'd4;
      ST_SCAN5: digit_idx_d = 3'd5;
      ST_SCAN6: digit_idx_d = 3'd6;
      ST_SCAN7: begin
        digit_idx_d  = 3'd7;
        frame_done_d = 1'b1;
      end
      default: begin
        cclr_neg_d = 1'b0;
        blank_d    = 1'b1;
      end
    endcase
  end

  // Frame FSM and its registered display strobes.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      state_q      <= ST_CLR;
      cclr_neg_q   <= 1'b0;
      blank_q      <= 1'b1;
      digit_idx_q  <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cclr_neg_q   <= cclr_neg_d;
      blank_q      <= blank_d;
      digit_idx_q  <= digit_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Once-per-frame arbitration; the owner's remaining hold is judged after this frame's decrement.
  always_comb begin
    owner_s   = (disp_src_q != IDLE_SRC);
    hold_m1_s = hold_cnt_q - 8'd1;
    expired_s = owner_s && (hold_m1_s == 8'd0);
    {found_s, j_s} = first_pending(pending_q);
    grant_s    = 1'b0;
    disp_val_d = disp_val_q;
    disp_src_d = disp_src_q;
    hold_cnt_d = hold_cnt_q;
    if (state_q == ST_SCAN7) begin
      if (found_s && (!owner_s || (j_s <= disp_src_q) || expired_s)) begin
        grant_s    = 1'b1;
        disp_val_d = slot_q[j_s];
        disp_src_d = j_s;
        hold_cnt_d = HOLD_INIT;
      end else if (owner_s && !expired_s) begin
        hold_cnt_d = hold_m1_s;
      end else begin
        disp_src_d = IDLE_SRC;
        disp_val_d = idle_val;
        hold_cnt_d = 8'd0;
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // A capture in the grant cycle re-arms pending, so the new value is shown at a later frame.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      grant_mask_s[i] = grant_s && (j_s == SRC_W'(i));
      pending_d[i]    = (pending_q[i] && !grant_mask_s[i]) || req[i];
      slot_d[i]       = req[i] ? val[32*i +: 32] : slot_q[i];
    end
  end

  // Request capture, acknowledge and display ownership registers.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        slot_q[i] <= 32'd0;
      end
      pending_q  <= {N_REQ{1'b0}};
      ack_q      <= {N_REQ{1'b0}};
      disp_val_q <= 32'd0;
      disp_src_q <= IDLE_SRC;
      hold_cnt_q <= 8'd0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        slot_q[i] <= slot_d[i];
      end
      pending_q  <= pending_d;
      ack_q      <= req;
      disp_val_q <= disp_val_d;
      disp_src_q <= disp_src_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign ack        = ack_q;
  assign disp_val   = disp_val_q;
  assign disp_src   = disp_src_q;
  assign cclr_neg   = cclr_neg_q;
  assign blank      = blank_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed display values.
module tb_display_scheduler;

  localparam int NR   = 3;
  localparam int HOLD = 16;

  logic          clk_out = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [32*NR-1:0] val;
  logic [NR-1:0] ack;
  logic [31:0]   idle_val;
  logic [31:0]   disp_val;
  logic [1:0]    disp_src;
  logic          cclr_neg;
  logic          blank;
  logic [2:0]    digit_idx;
  logic          frame_done;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  display_scheduler #(.N_REQ(NR), .HOLD_FRAMES(HOLD), .SRC_W(2)) dut (
    .clk_out(clk_out), .rst(rst), .req(req), .val(val), .ack(ack),
    .idle_val(idle_val), .disp_val(disp_val), .disp_src(disp_src),
    .cclr_neg(cclr_neg), .blank(blank), .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk_out = ~clk_out;

  // Reference model: position within the 10-cycle frame, owner (-1 = idle), frames left.
  int          m_phase;
  int          m_owner;
  int          m_hold;
  logic [31:0] m_disp;
  logic [31:0] m_slot [NR];
  bit          m_pend [NR];
  logic [NR-1:0] m_ack;

  always @(posedge clk_out) begin
    if (rst) begin
      m_phase = 0; m_owner = -1; m_hold = 0; m_disp = 32'd0; m_ack = '0;
      for (int i = 0; i < NR; i++) begin m_pend[i] = 1'b0; m_slot[i] = 32'd0; end
    end else begin
      if (m_phase == 9) begin
        int  j;
        bit  expired;
        j = -1;
        for (int i = NR - 1; i >= 0; i--) if (m_pend[i]) j = i;
        expired = (m_owner >= 0) && (m_hold - 1 == 0);
        if (j >= 0 && (m_owner < 0 || j <= m_owner || expired)) begin
          m_disp = m_slot[j]; m_owner = j; m_hold = HOLD; m_pend[j] = 1'b0;
        end else if (m_owner >= 0 && !expired) begin
          m_hold = m_hold - 1;
        end else begin
          m_owner = -1; m_disp = idle_val;
        end
      end
      m_phase = (m_phase + 1) % 10;
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin m_slot[i] = val[32*i +: 32]; m_pend[i] = 1'b1; end
      end
      m_ack = req;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_out) begin
    if (chk_en) begin
      chk("cclr_neg",   {31'd0, cclr_neg},   (m_phase != 0) ? 32'd1 : 32'd0);
      chk("blank",      {31'd0, blank},      (m_phase < 2) ? 32'd1 : 32'd0);
      chk("digit_idx",  {29'd0, digit_idx},  (m_phase >= 2) ? 32'(m_phase - 2) : 32'd0);
      chk("frame_done", {31'd0, frame_done}, (m_phase == 9) ? 32'd1 : 32'd0);
      chk("ack",        {29'd0, ack},        {29'd0, m_ack});
      chk("disp_val",   disp_val,            m_disp);
      chk("disp_src",   {30'd0, disp_src},   (m_owner < 0) ? 32'd3 : 32'(m_owner));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_out);
  endtask

  task automatic pulse(input logic [NR-1:0] r, input int idx, input logic [31:0] v);
    req = r;
    val[32*idx +: 32] = v;
  endtask

  // Literal checks are taken 1 time unit after the falling edge.
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    #1 chk(nm, act, exp);
  endtask

  initial begin
    rst = 1'b1; req = '0; val = '0; idle_val = 32'h0001E240;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    rst = 1'b0;                      // first CLR cycle of frame 1
    lit("t1_clr", {31'd0, cclr_neg}, 32'd0);
    lit("t1_src_rst", {30'd0, disp_src}, 32'd3);
    cyc(9);
    lit("t1_done", {31'd0, frame_done}, 32'd1);
    lit("t1_dig7", {29'd0, digit_idx}, 32'd7);
    lit("t1_val_f1", disp_val, 32'd0);
    cyc(1);
    lit("t1_val_f2", disp_val, 32'h0001E240);
    lit("t1_src_f2", {30'd0, disp_src}, 32'd3);

    // requester 1 mid-frame
    cyc(3);
    pulse(3'b010, 1, 32'h00000150);
    cyc(1); req = '0;
    lit("t2_ack", {29'd0, ack}, 32'd2);
    cyc(6);
    lit("t2_val", disp_val, 32'h00000150);
    lit("t2_src", {30'd0, disp_src}, 32'd1);
    idle_val = 32'h00012345;
    cyc(159);
    lit("t2_last", {30'd0, disp_src}, 32'd1);
    cyc(1);
    lit("t2_idle_src", {30'd0, disp_src}, 32'd3);
    lit("t2_idle_val", disp_val, 32'h00012345);

    // owner 2 preempted by requester 0
    pulse(3'b100, 2, 32'h00000099);
    cyc(1); req = '0;
    cyc(9);
    lit("t3_own2", disp_val, 32'h00000099);
    cyc(25);
    pulse(3'b001, 0, 32'h000000E1);
    cyc(1); req = '0;
    cyc(4);
    lit("t3_pre_val", disp_val, 32'h000000E1);
    lit("t3_pre_src", {30'd0, disp_src}, 32'd0);
    cyc(160);
    lit("t3_idle", {30'd0, disp_src}, 32'd3);

    // lower priority waits for the owner to expire
    pulse(3'b001, 0, 32'h00000010);
    cyc(1); req = '0;
    cyc(9);
    lit("t4_own0", disp_val, 32'h00000010);
    cyc(3);
    pulse(3'b100, 2, 32'h00000077);
    cyc(1); req = '0;
    cyc(146);
    lit("t4_still0", {30'd0, disp_src}, 32'd0);
    cyc(10);
    lit("t4_val2", disp_val, 32'h00000077);
    lit("t4_src2", {30'd0, disp_src}, 32'd2);
    cyc(160);
    lit("t4_idle", {30'd0, disp_src}, 32'd3);

    // simultaneous requests 0 and 1
    req = 3'b011; val[31:0] = 32'h000000AA; val[63:32] = 32'h000000BB;
    cyc(1); req = '0;
    lit("t5_ack", {29'd0, ack}, 32'd3);
    cyc(9);
    lit("t5_aa", disp_val, 32'h000000AA);
    cyc(160);
    lit("t5_bb", disp_val, 32'h000000BB);
    lit("t5_src1", {30'd0, disp_src}, 32'd1);
    cyc(160);
    lit("t5_idle", disp_val, 32'h00012345);

    // reset in SCAN4 with requester 1 pending
    pulse(3'b010, 1, 32'h00000055);
    cyc(1); req = '0;
    cyc(5);
    rst = 1'b1; pulse(3'b100, 2, 32'h00000066);
    cyc(1);
    lit("t6_cclr", {31'd0, cclr_neg}, 32'd0);
    lit("t6_blank", {31'd0, blank}, 32'd1);
    lit("t6_src", {30'd0, disp_src}, 32'd3);
    lit("t6_val", disp_val, 32'd0);
    rst = 1'b0; req = '0;
    cyc(1);
    lit("t6_noack", {29'd0, ack}, 32'd0);
    cyc(9);
    lit("t6_idle", disp_val, 32'h00012345);
    cyc(10);
    lit("t6_nostale", {30'd0, disp_src}, 32'd3);
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
